// File: rtl/lut_neuron_loader.sv
// rtl/lut_neuron_loader.sv - runtime-loadable bank of LUT neurons with framed config stream and registered lookup
module lut_neuron_loader #(
    parameter int NUM_NEURONS = 8,
    parameter int IN_BITS     = 6,
    parameter int CFG_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [CFG_W-1:0]               cfg_data,
    input  logic                           cfg_last,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0] in_addr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_NEURONS-1:0]         out_data,
    output logic                           armed,
    output logic                           cfg_err
);

    localparam int D   = 1 << IN_BITS;
    localparam int BPN = D / CFG_W;
    localparam int T   = NUM_NEURONS * BPN;
    localparam int BCW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_ARMED,
        S_ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic [BCW-1:0]           bc_q, bc_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     out_valid_q, out_valid_d;
    logic [NUM_NEURONS-1:0]   out_data_q, out_data_d;

    logic [D-1:0]             tbl_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   rd_bits;
    logic                     wr_en;
    logic [BCW-1:0]           wr_idx;
    logic                     beat_acc;
    logic                     look_acc;

    // Config is only refused while reset is held; lookups need a complete table set
    // and room in the output register.
    assign cfg_ready = !rst;
    assign armed     = (state_q == S_ARMED);
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign in_ready  = armed && (!out_valid_q || out_ready);
    assign beat_acc  = cfg_valid && cfg_ready;
    assign look_acc  = in_valid && in_ready;

    // Load framing FSM: decides where each accepted beat lands and whether the load arms or fails.
    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        cfg_err_d = cfg_err_q;
        wr_en     = 1'b0;
        wr_idx    = '0;
        if (beat_acc) begin
            case (state_q)
                S_EMPTY, S_ARMED: begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    cfg_err_d = 1'b0;
                    if (cfg_last && (T == 1)) begin
                        state_d = S_ARMED;
                        bc_d    = '0;
                    end else begin
                        state_d = S_LOADING;
                        bc_d    = BCW'(1);
                    end
                end
                S_LOADING: begin
                    wr_en  = 1'b1;
                    wr_idx = bc_q;
                    if (bc_q == BCW'(T - 1)) begin
                        bc_d = '0;
                        if (cfg_last) begin
                            state_d = S_ARMED;
                        end else begin
                            state_d   = S_ERROR;
                            cfg_err_d = 1'b1;
                        end
                    end else if (cfg_last) begin
                        state_d   = S_ERROR;
                        cfg_err_d = 1'b1;
                        bc_d      = '0;
                    end else begin
                        bc_d = bc_q + BCW'(1);
                    end
                end
                S_ERROR: begin
                    if (cfg_last) begin
                        state_d = S_EMPTY;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Table read: one bit per neuron, addressed by that neuron's slice of in_addr.
    always_comb begin
        rd_bits = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            rd_bits[n] = tbl_q[n][in_addr[n*IN_BITS +: IN_BITS]];
        end
    end

    // Output register: load on accept, drop valid once consumed, otherwise hold stable.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (look_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_bits;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            bc_q        <= '0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Truth-table RAM: no reset, written one CFG_W slice per beat; reads see pre-write data.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            for (int b = 0; b < BPN; b++) begin
                if (wr_en && (wr_idx == BCW'(n * BPN + b))) begin
                    tbl_q[n][b*CFG_W +: CFG_W] <= cfg_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb/tb_lut_neuron_loader.sv - randomized self-checking bench for lut_neuron_loader
module tb_lut_neuron_loader;

    localparam int NN   = 8;
    localparam int IB   = 6;
    localparam int CW   = 16;
    localparam int BPN  = 4;
    localparam int TOT  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_data;
    logic           cfg_last;
    logic           in_valid;
    logic           in_ready;
    logic [NN*IB-1:0] in_addr;
    logic           out_valid;
    logic           out_ready;
    logic [NN-1:0]  out_data;
    logic           armed;
    logic           cfg_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] load_tbl [NN];
    logic [63:0] exp_tbl  [NN];

    lut_neuron_loader #(.NUM_NEURONS(NN), .IN_BITS(IB), .CFG_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .armed(armed), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        rotl = (x << n) | (x >> (64 - n));
    endfunction

    // Reference lookup: bit n of the result is entry addr_n of neuron n's table.
    function automatic logic [NN-1:0] model_lookup(input logic [NN*IB-1:0] a);
        logic [NN-1:0] r;
        for (int n = 0; n < NN; n++) begin
            r[n] = exp_tbl[n][a[n*IB +: IB]];
        end
        return r;
    endfunction

    function automatic logic [NN*IB-1:0] rand_addr();
        logic [NN*IB-1:0] a;
        for (int n = 0; n < NN; n++) a[n*IB +: IB] = IB'($urandom_range(0, 63));
        return a;
    endfunction

    task automatic rand_tables();
        for (int n = 0; n < NN; n++) load_tbl[n] = {$urandom, $urandom};
    endtask

    task automatic commit_model();
        for (int n = 0; n < NN; n++) exp_tbl[n] = load_tbl[n];
    endtask

    // Sends beats [first, stop); beat last_at carries cfg_last (-1: none).
    task automatic send_beats(input int first, input int stop, input int last_at);
        for (int b = first; b < stop; b++) begin
            cfg_valid = 1'b1;
            cfg_data  = load_tbl[(b % TOT) / BPN][((b % TOT) % BPN) * CW +: CW];
            cfg_last  = (b == last_at);
            #1;
            chk("cfg_ready_beat", {63'd0, cfg_ready}, 64'd1);
            tick();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic full_load_expect_armed(input string tag);
        send_beats(0, TOT, TOT - 1);
        commit_model();
        chk({tag, "_armed"}, {63'd0, armed}, 64'd1);
        chk({tag, "_cfg_err"}, {63'd0, cfg_err}, 64'd0);
    endtask

    // Back-to-back lookups with out_ready high: one result per cycle.
    task automatic lookups(input int count, input bit sweep);
        logic [NN*IB-1:0] a;
        for (int i = 0; i < count; i++) begin
            if (sweep) begin
                for (int n = 0; n < NN; n++) a[n*IB +: IB] = IB'(i);
            end else begin
                a = rand_addr();
            end
            in_addr   = a;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            chk("lookup_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
            chk("lookup_out_valid", {63'd0, out_valid}, 64'd1);
            chk("lookup_out_data", {56'd0, out_data}, {56'd0, model_lookup(a)});
        end
        in_valid = 1'b0;
        tick();
        chk("lookup_drain_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [NN*IB-1:0] a0, a1;
        logic [NN-1:0]    e0, e1;

        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
        in_valid = 1'b0; in_addr = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        chk("rst_armed", {63'd0, armed}, 64'd0);
        chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("cfg_ready_after_rst", {63'd0, cfg_ready}, 64'd1);

        // Rotated pattern tables, full sweep of every address.
        for (int n = 0; n < NN; n++) load_tbl[n] = rotl(64'hCC00CC00_FF00FF00, n);
        send_beats(0, TOT - 1, -1);
        chk("loading_not_armed", {63'd0, armed}, 64'd0);
        send_beats(TOT - 1, TOT, TOT - 1);
        commit_model();
        chk("pattern_armed", {63'd0, armed}, 64'd1);
        chk("pattern_cfg_err", {63'd0, cfg_err}, 64'd0);
        lookups(64, 1'b1);

        // Early cfg_last at beat 20, discard beats, then a clean reload.
        rand_tables();
        send_beats(0, 21, 20);
        chk("early_last_cfg_err", {63'd0, cfg_err}, 64'd1);
        chk("early_last_armed", {63'd0, armed}, 64'd0);
        in_valid = 1'b1; in_addr = rand_addr();
        #1;
        chk("early_last_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("early_last_no_out", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        send_beats(21, 24, -1);
        chk("discard_cfg_err", {63'd0, cfg_err}, 64'd1);
        send_beats(24, 25, 24);
        chk("err_exit_cfg_err_held", {63'd0, cfg_err}, 64'd1);
        chk("err_exit_armed", {63'd0, armed}, 64'd0);
        rand_tables();
        full_load_expect_armed("reload1");
        lookups(24, 1'b0);

        // Missing cfg_last on final beat: error, lookups refused, then overwrite.
        rand_tables();
        send_beats(0, TOT, -1);
        chk("no_last_cfg_err", {63'd0, cfg_err}, 64'd1);
        chk("no_last_armed", {63'd0, armed}, 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_addr = rand_addr();
            #1;
            chk("no_last_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            chk("no_last_out_valid", {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b0;
        send_beats(0, 1, 0);
        rand_tables();
        full_load_expect_armed("reload2");
        lookups(64, 1'b1);

        // Backpressure: result held stable while out_ready is low.
        a0 = rand_addr(); e0 = model_lookup(a0);
        a1 = rand_addr(); e1 = model_lookup(a1);
        in_addr = a0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("bp_first_data", {56'd0, out_data}, {56'd0, e0});
        out_ready = 1'b0; in_addr = a1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            tick();
            chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
            chk("bp_data_held", {56'd0, out_data}, {56'd0, e0});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_second_data", {56'd0, out_data}, {56'd0, e1});
        in_valid = 1'b0;
        tick();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        chk("bp_data_kept", {56'd0, out_data}, {56'd0, e1});

        // Lookup and reload start on the same edge: old contents returned.
        rand_tables();
        load_tbl[0][0] = 1'b1;
        full_load_expect_armed("rbw_old");
        e0 = model_lookup('0);
        rand_tables();
        load_tbl[0][0] = 1'b0;
        cfg_valid = 1'b1; cfg_last = 1'b0; cfg_data = load_tbl[0][CW-1:0];
        in_valid = 1'b1; in_addr = '0; out_ready = 1'b1;
        #1;
        chk("rbw_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        cfg_valid = 1'b0; in_valid = 1'b0;
        chk("rbw_old_bit", {63'd0, out_data[0]}, 64'd1);
        chk("rbw_old_word", {56'd0, out_data}, {56'd0, e0});
        chk("rbw_armed_dropped", {63'd0, armed}, 64'd0);
        chk("rbw_out_valid", {63'd0, out_valid}, 64'd1);
        send_beats(1, TOT, TOT - 1);
        commit_model();
        chk("rbw_new_armed", {63'd0, armed}, 64'd1);
        in_addr = '0;
        lookups(1, 1'b1);
        chk("rbw_new_bit", {63'd0, out_data[0]}, 64'd0);
        lookups(16, 1'b0);

        // Reset in the middle of a load.
        rand_tables();
        send_beats(0, 10, -1);
        cfg_valid = 1'b1; cfg_data = load_tbl[2][2*CW +: CW]; rst = 1'b1;
        #1;
        chk("midrst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        tick();
        cfg_valid = 1'b0; rst = 1'b0;
        chk("midrst_armed", {63'd0, armed}, 64'd0);
        chk("midrst_cfg_err", {63'd0, cfg_err}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_data", {56'd0, out_data}, 64'd0);
        rand_tables();
        full_load_expect_armed("post_rst");
        lookups(32, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
